// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point add/subtract pipeline:
// default field widths, flag bit positions, operand classes and special encodings.
package fp_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;

  localparam int FLG_INVALID   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set.
  function automatic logic [63:0] qnan_bits(input int exp_w, input int man_w);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] inf_bits(input int exp_w, input int man_w, input logic sign);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
    v[exp_w + man_w] = sign;
    return v;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; cnt equals W when the input is all zero.
module fp_lzc #(
  parameter  int W     = 25,
  localparam int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     din,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // Ascending scan: the highest set bit is the last to write cnt.
  always_comb begin
    cnt = CNT_W'(W);
    for (int i = 0; i < W; i++)
      if (din[i]) cnt = CNT_W'(W - 1 - i);
  end

  assign zero = ~|din;

endmodule

// File: rtl/fp_add_sub_pipe.sv
// Three-stage floating-point adder/subtractor (align, add, normalise/round)
// with round-to-nearest-even, flush-to-zero and a single global stall.
module fp_add_sub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int MAN_W  = MAN_W_DEF,
  parameter int DATA_W = 1 + EXP_W + MAN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] r,
  output logic [3:0]        flags
);

  localparam int SIG_W = MAN_W + 4;
  localparam int SUM_W = MAN_W + 5;
  localparam int LZC_W = MAN_W + 2;
  localparam int CNT_W = $clog2(LZC_W + 1);
  localparam int EW    = EXP_W + 2;
  localparam int MAG_W = EXP_W + MAN_W;
  localparam logic [EXP_W-1:0]  EXP_MAX = '1;
  localparam logic [DATA_W-1:0] QNAN    = DATA_W'(qnan_bits(EXP_W, MAN_W));
  localparam logic [DATA_W-1:0] POS_INF = DATA_W'(inf_bits(EXP_W, MAN_W, 1'b0));
  localparam logic [DATA_W-1:0] NEG_INF = DATA_W'(inf_bits(EXP_W, MAN_W, 1'b1));

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    if (e == '0) return ZERO;
    if (e == EXP_MAX) return (m == '0) ? INF : NAN;
    return NORM;
  endfunction

  function automatic logic [SIG_W-1:0] align(input logic [SIG_W-1:0] sig, input logic [EXP_W-1:0] d);
    logic [2*SIG_W-1:0] wide;
    if (int'(d) >= MAN_W + 3) return {{(SIG_W-1){1'b0}}, |sig};
    wide = {sig, {SIG_W{1'b0}}} >> d;
    return {wide[2*SIG_W-1:SIG_W+1], wide[SIG_W] | (|wide[SIG_W-1:0])};
  endfunction

  // Returns {mantissa carry-out, rounded stored mantissa}; hidden bit is always set here.
  function automatic logic [MAN_W:0] round_rne(input logic [SIG_W-1:0] m);
    logic up;
    up = m[2] & (m[1] | m[0] | m[3]);
    return {up & (&m[SIG_W-1:3]), m[SIG_W-2:3] + {{(MAN_W-1){1'b0}}, up}};
  endfunction

  function automatic logic [DATA_W+3:0] saturate(input logic sign,
                                                 input logic signed [EW-1:0] e_norm,
                                                 input logic signed [EW-1:0] e_rnd,
                                                 input logic [MAN_W-1:0] man,
                                                 input logic inexact);
    logic [3:0] f;
    f = '0;
    f[FLG_INEXACT] = inexact;
    if (e_norm[EW-1] || e_norm == '0) begin
      f[FLG_UNDERFLOW] = 1'b1;
      f[FLG_INEXACT]   = 1'b1;
      return {f, sign, {(DATA_W-1){1'b0}}};
    end
    if (!e_rnd[EW-1] && e_rnd[EW-2:0] >= {1'b0, EXP_MAX}) begin
      f[FLG_OVERFLOW] = 1'b1;
      f[FLG_INEXACT]  = 1'b1;
      return {f, sign ? NEG_INF : POS_INF};
    end
    return {f, sign, e_rnd[EXP_W-1:0], man};
  endfunction

  logic vld_p1, vld_p2, vld_p3;
  logic stall;

  assign stall     = vld_p3 & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_p3;

  // ---- stage 1: classify, specials, swap and align ----
  logic              sign_a, sign_b, swap, spec_hit, spec_inv;
  fp_class_e         cls_a, cls_b;
  logic [MAG_W-1:0]  mag_a, mag_b, mag_x, mag_y;
  logic [EXP_W-1:0]  d;
  logic [SIG_W-1:0]  sig_x, sig_y;
  logic [DATA_W-1:0] spec_r;

  always_comb begin
    sign_a = a[DATA_W-1];
    sign_b = b[DATA_W-1] ^ sub;
    cls_a  = classify(a[DATA_W-2:MAN_W], a[MAN_W-1:0]);
    cls_b  = classify(b[DATA_W-2:MAN_W], b[MAN_W-1:0]);
    mag_a  = (cls_a == ZERO) ? '0 : a[DATA_W-2:0];
    mag_b  = (cls_b == ZERO) ? '0 : b[DATA_W-2:0];
    swap   = mag_b > mag_a;
    mag_x  = swap ? mag_b : mag_a;
    mag_y  = swap ? mag_a : mag_b;
    d      = mag_x[MAG_W-1:MAN_W] - mag_y[MAG_W-1:MAN_W];
    sig_x  = {|mag_x[MAG_W-1:MAN_W], mag_x[MAN_W-1:0], 3'b000};
    sig_y  = align({|mag_y[MAG_W-1:MAN_W], mag_y[MAN_W-1:0], 3'b000}, d);

    spec_hit = 1'b1;
    spec_inv = 1'b0;
    spec_r   = QNAN;
    if (cls_a == NAN || cls_b == NAN) spec_r = QNAN;
    else if (cls_a == INF && cls_b == INF && sign_a != sign_b) spec_inv = 1'b1;
    else if (cls_a == INF) spec_r = sign_a ? NEG_INF : POS_INF;
    else if (cls_b == INF) spec_r = sign_b ? NEG_INF : POS_INF;
    else if (cls_a == ZERO && cls_b == ZERO) spec_r = {sign_a & sign_b, {(DATA_W-1){1'b0}}};
    else spec_hit = 1'b0;
  end

  logic              sign_p1, eff_sub_p1, spec_hit_p1, spec_inv_p1;
  logic [EXP_W-1:0]  exp_p1;
  logic [SIG_W-1:0]  sig_x_p1, sig_y_p1;
  logic [DATA_W-1:0] spec_r_p1;

  always_ff @(posedge clk) begin
    if (!stall) begin
      sign_p1     <= swap ? sign_b : sign_a;
      eff_sub_p1  <= sign_a ^ sign_b;
      exp_p1      <= mag_x[MAG_W-1:MAN_W];
      sig_x_p1    <= sig_x;
      sig_y_p1    <= sig_y;
      spec_hit_p1 <= spec_hit;
      spec_inv_p1 <= spec_inv;
      spec_r_p1   <= spec_r;
    end
  end

  // ---- stage 2: significand add/subtract (never negative after the swap) ----
  logic              sign_p2, spec_hit_p2, spec_inv_p2;
  logic [EXP_W-1:0]  exp_p2;
  logic [SUM_W-1:0]  sum_p2;
  logic [DATA_W-1:0] spec_r_p2;

  always_ff @(posedge clk) begin
    if (!stall) begin
      sum_p2      <= eff_sub_p1 ? ({1'b0, sig_x_p1} - {1'b0, sig_y_p1})
                                : ({1'b0, sig_x_p1} + {1'b0, sig_y_p1});
      sign_p2     <= sign_p1;
      exp_p2      <= exp_p1;
      spec_hit_p2 <= spec_hit_p1;
      spec_inv_p2 <= spec_inv_p1;
      spec_r_p2   <= spec_r_p1;
    end
  end

  // ---- stage 3: normalise, round, saturate ----
  // Cancellation only reaches below the guard bit when d<=1, where round/sticky
  // are zero, so counting over the top MAN_W+2 bits is sufficient.
  logic [CNT_W-1:0]     lz;
  logic                 lz_zero;
  logic signed [EW-1:0] e_base, e_norm, e_rnd;
  logic [SIG_W-1:0]     norm;
  logic [MAN_W:0]       rnd;
  logic [DATA_W-1:0]    r_n;
  logic [3:0]           flags_n;

  fp_lzc #(.W(LZC_W)) u_lzc (
    .din  (sum_p2[SIG_W-1:2]),
    .cnt  (lz),
    .zero (lz_zero)
  );

  assign e_base = $signed({2'b00, exp_p2});

  always_comb begin
    if (sum_p2[SUM_W-1]) begin
      norm   = {sum_p2[SUM_W-1:2], sum_p2[1] | sum_p2[0]};
      e_norm = e_base + $signed({{(EW-1){1'b0}}, 1'b1});
    end else begin
      norm   = sum_p2[SIG_W-1:0] << lz;
      e_norm = e_base - $signed({{(EW-CNT_W){1'b0}}, lz});
    end
    rnd   = round_rne(norm);
    e_rnd = e_norm + $signed({{(EW-1){1'b0}}, rnd[MAN_W]});

    flags_n = '0;
    r_n     = '0;
    if (spec_hit_p2) begin
      flags_n[FLG_INVALID] = spec_inv_p2;
      r_n = spec_r_p2;
    end else if (!(!sum_p2[SUM_W-1] && lz_zero)) begin
      {flags_n, r_n} = saturate(sign_p2, e_norm, e_rnd, rnd[MAN_W-1:0], |norm[2:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      r      <= '0;
      flags  <= '0;
    end else if (!stall) begin
      vld_p1 <= in_valid & in_ready;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      r      <= r_n;
      flags  <= flags_n;
    end
  end

endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// Directed bench for fp_add_sub_pipe: reset, arithmetic cases, specials,
// back-pressure streaming and reset with operations in flight.
module tb_fp_add_sub_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] r;
  logic [3:0]  flags;

  int checks = 0;
  int passed = 0;

  fp_add_sub_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .flags(flags)
  );

  always #5 clk = ~clk;

  // Drives one beat and waits (bounded) for its result; called #1 after an edge.
  task automatic send_one(input logic [31:0] ta, input logic [31:0] tb_in, input logic ts,
                          output logic [31:0] rr, output logic [3:0] ff, output int lat);
    a = ta; b = tb_in; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rr = r; ff = flags;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    checks++; if (r !== 32'h0) $display("FAIL reset_r got %h want 00000000", r); else passed++;
    checks++; if (flags !== 4'h0) $display("FAIL reset_flags got %b want 0000", flags); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_add();
    logic [31:0] rr; logic [3:0] ff; int lat;
    send_one(32'h3F800000, 32'h40000000, 1'b0, rr, ff, lat);
    checks++; if (rr !== 32'h40400000) $display("FAIL add_1p2 got %h want 40400000", rr); else passed++;
    checks++; if (ff !== 4'b0000) $display("FAIL add_1p2_flags got %b want 0000", ff); else passed++;
    // out_valid rises on the third rising edge counting the one that accepts the beat
    checks++; if (lat !== 3) $display("FAIL add_latency got %0d want 3", lat); else passed++;
  endtask

  task automatic test_cancel();
    logic [31:0] rr; logic [3:0] ff; int lat;
    send_one(32'h3F800000, 32'h3F800000, 1'b1, rr, ff, lat);
    checks++; if (rr !== 32'h00000000) $display("FAIL cancel_exact got %h want 00000000", rr); else passed++;
    checks++; if (ff !== 4'b0000) $display("FAIL cancel_exact_flags got %b want 0000", ff); else passed++;
    send_one(32'h3F800001, 32'h3F800000, 1'b1, rr, ff, lat);
    checks++; if (rr !== 32'h34000000) $display("FAIL cancel_ulp got %h want 34000000", rr); else passed++;
    checks++; if (ff !== 4'b0000) $display("FAIL cancel_ulp_flags got %b want 0000", ff); else passed++;
  endtask

  task automatic test_round();
    logic [31:0] rr; logic [3:0] ff; int lat;
    send_one(32'h3F800000, 32'h33800000, 1'b0, rr, ff, lat);
    checks++; if (rr !== 32'h3F800000) $display("FAIL round_tie_even got %h want 3F800000", rr); else passed++;
    checks++; if (ff !== 4'b0001) $display("FAIL round_tie_flags got %b want 0001", ff); else passed++;
    send_one(32'h3F800000, 32'h33800001, 1'b0, rr, ff, lat);
    checks++; if (rr !== 32'h3F800001) $display("FAIL round_up got %h want 3F800001", rr); else passed++;
    checks++; if (ff !== 4'b0001) $display("FAIL round_up_flags got %b want 0001", ff); else passed++;
  endtask

  task automatic test_specials();
    logic [31:0] va [8] = '{32'h7F7FFFFF, 32'h7F800000, 32'h7F800001, 32'hFF800000,
                            32'h00000000, 32'h80000000, 32'h00800001, 32'h00000001};
    logic [31:0] vb [8] = '{32'h7F7FFFFF, 32'h7F800000, 32'h3F800000, 32'h3F800000,
                            32'h80000000, 32'h80000000, 32'h00800000, 32'h3F800000};
    logic        vs [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] vr [8] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000,
                            32'h00000000, 32'h80000000, 32'h00000000, 32'h3F800000};
    logic [3:0]  vf [8] = '{4'b0101, 4'b1000, 4'b0000, 4'b0000,
                            4'b0000, 4'b0000, 4'b0011, 4'b0000};
    logic [31:0] rr; logic [3:0] ff; int lat;
    for (int i = 0; i < 8; i++) begin
      send_one(va[i], vb[i], vs[i], rr, ff, lat);
      checks++; if (rr !== vr[i]) $display("FAIL special_%0d_r got %h want %h", i, rr, vr[i]); else passed++;
      checks++; if (ff !== vf[i]) $display("FAIL special_%0d_flags got %b want %b", i, ff, vf[i]); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [8] = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'h40400000,
                            32'hBF800000, 32'h41200000, 32'h00000000, 32'h42C80000};
    logic [31:0] vb [8] = '{32'h3F800000, 32'h3F800000, 32'h3E800000, 32'h40A00000,
                            32'h3F000000, 32'h3F000000, 32'hC0400000, 32'h3E800000};
    logic        vs [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] vr [8] = '{32'h40000000, 32'h3F800000, 32'h3FE00000, 32'hC0000000,
                            32'hBF000000, 32'h41280000, 32'hC0400000, 32'h42C78000};
    int sent = 0, got = 0, cyc = 0, stall_cycles = 0;
    logic was_stalled = 1'b0, acc;
    logic [31:0] held_r = '0;
    logic [3:0]  held_f = '0;
    while (got < 8 && cyc < 200) begin
      out_ready = !(cyc >= 6 && cyc < 11);
      in_valid  = (sent < 8);
      if (sent < 8) begin a = va[sent]; b = vb[sent]; sub = vs[sent]; end
      #1;
      if (was_stalled) begin
        checks++;
        if ({out_valid, r, flags} !== {1'b1, held_r, held_f})
          $display("FAIL stall_hold got %b/%h/%b want 1/%h/%b", out_valid, r, flags, held_r, held_f);
        else passed++;
      end
      acc = in_valid && in_ready;
      was_stalled = out_valid && !out_ready;
      if (was_stalled) begin
        stall_cycles++;
        held_r = r; held_f = flags;
        checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got %b want 0", in_ready); else passed++;
      end
      if (out_valid && out_ready) begin
        checks++; if (r !== vr[got]) $display("FAIL bp_result_%0d got %h want %h", got, r, vr[got]); else passed++;
        checks++; if (flags !== 4'b0000) $display("FAIL bp_flags_%0d got %b want 0000", got, flags); else passed++;
        got++;
      end
      @(posedge clk); #1;
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got !== 8) $display("FAIL bp_count got %0d want 8", got); else passed++;
    checks++; if (stall_cycles !== 5) $display("FAIL bp_stall_cycles got %0d want 5", stall_cycles); else passed++;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 32'h3F800000; b = 32'h3F800000; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) $display("FAIL midflight_loaded got %b want 1", out_valid); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL midflight_out_valid got %b want 0", out_valid); else passed++;
    checks++; if (r !== 32'h0) $display("FAIL midflight_r got %h want 00000000", r); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL midflight_in_ready got %b want 1", in_ready); else passed++;
    repeat (6) begin
      if (out_valid) stale++;
      @(posedge clk); #1;
    end
    checks++; if (stale !== 0) $display("FAIL midflight_stale got %0d want 0", stale); else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_cancel();
    test_round();
    test_specials();
    test_back_to_back();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
